// File: rtl/pixel_pll_supervisor.sv
// pixel_pll_supervisor
//   Sequences the pixel PLL from the 50 MHz reference clock domain. It pulses the
//   PLL reset, waits for lock under a per-attempt timeout, retries a bounded number
//   of times and filters lock glitches. The downstream reset is released only after
//   lock has been continuously present for STABLE_CYCLES cycles. Loss of lock, or a
//   relock request while running, starts a fresh sequence.
//
// Ports
//   clk          in   reference clock (same source as the PLL refclk)
//   rst          in   synchronous, active-high reset
//   pll_locked   in   PLL lock indicator, asynchronous to clk
//   relock_req   in   one-cycle pulse: restart the sequence (acted on in RUN/FAULT)
//   pll_rst      out  PLL reset
//   sys_rst      out  downstream reset, active-high, clk domain
//   ready        out  pixel clock valid and downstream released
//   fault        out  retries exhausted, PLL held in reset
//   retry_count  out  retries consumed in the current sequence
//   state        out  debug: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT

module pixel_pll_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 2000000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic relock_req,
  output logic pll_rst,
  output logic sys_rst,
  output logic ready,
  output logic fault,
  output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1)-1:0] retry_count,
  output logic [2:0] state
);

  localparam int RW  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int TCW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SCW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [RCW-1:0]         rcnt_q, rcnt_d;    // cycles spent in PLL_RST
  logic [TCW-1:0]         tcnt_q, tcnt_d;    // cycles spent in WAIT_LOCK+STABLE this attempt
  logic [SCW-1:0]         scnt_q, scnt_d;    // consecutive locked cycles in STABLE
  logic [RW-1:0]          retry_q, retry_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pll_rst_q, sys_rst_q, ready_q, fault_q;

  logic locked_s;
  logic timeout;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign timeout  = (tcnt_q == TCW'(LOCK_TIMEOUT - 1));

  // Next-state and counter updates. The timeout branch is shared by WAIT_LOCK and
  // STABLE; in STABLE a completed stability window takes precedence over it.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    retry_d = retry_q;
    unique case (state_q)
      S_PLL_RST: begin
        if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          rcnt_d  = '0;
          tcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      S_WAIT_LOCK, S_STABLE: begin
        if ((state_q == S_STABLE) && locked_s && (scnt_q == SCW'(STABLE_CYCLES - 1))) begin
          state_d = S_RUN;
        end else if (timeout) begin
          if (retry_q == RW'(MAX_RETRIES)) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_PLL_RST;
            retry_d = retry_q + RW'(1);
            rcnt_d  = '0;
          end
        end else begin
          tcnt_d = tcnt_q + TCW'(1);
          if (state_q == S_WAIT_LOCK) begin
            if (locked_s) begin
              state_d = S_STABLE;
              scnt_d  = '0;
            end
          end else if (locked_s) begin
            scnt_d = scnt_q + SCW'(1);
          end else begin
            // Glitch: restart the stability window but keep the attempt timer.
            state_d = S_WAIT_LOCK;
            scnt_d  = '0;
          end
        end
      end
      S_RUN: begin
        if (!locked_s || relock_req) begin
          state_d = S_PLL_RST;
          retry_d = '0;
          rcnt_d  = '0;
        end
      end
      S_FAULT: begin
        if (relock_req) begin
          state_d = S_PLL_RST;
          retry_d = '0;
          rcnt_d  = '0;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        rcnt_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as
  // the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_PLL_RST;
      rcnt_q    <= '0;
      tcnt_q    <= '0;
      scnt_q    <= '0;
      retry_q   <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      tcnt_q    <= tcnt_d;
      scnt_q    <= scnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_d == S_PLL_RST) || (state_d == S_FAULT);
      sys_rst_q <= (state_d != S_RUN);
      ready_q   <= (state_d == S_RUN);
      fault_q   <= (state_d == S_FAULT);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pixel_pll_supervisor.sv
// tb_pixel_pll_supervisor
//   Directed scenarios followed by a randomized lock/relock/reset run, every cycle
//   compared against an elapsed-time model of the supervisor. Latencies are counted
//   in clock edges from the edge after which an input was changed.

module tb_pixel_pll_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int SYNC_STAGES   = 2;

  localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst, pll_locked, relock_req;
  logic       pll_rst, sys_rst, ready, fault;
  logic [1:0] retry_count;
  logic [2:0] state;

  pixel_pll_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: phase plus elapsed-time bookkeeping.
  int m_phase, m_elapsed, m_attempt, m_run, m_retries;
  bit m_hist[$];          // last SYNC_STAGES samples of pll_locked, oldest first
  int prev_state = 0;
  int stable_drops = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic m_clear_hist();
    m_hist = {};
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
  endtask

  task automatic m_enter_rst();
    m_phase   = P_RST;
    m_elapsed = 0;
  endtask

  task automatic m_timeout();
    if (m_retries == MAX_RETRIES) m_phase = P_FAULT;
    else begin
      m_retries++;
      m_enter_rst();
    end
  endtask

  task automatic model_edge();
    bit ls;
    ls = m_hist[0];
    if (rst) begin
      m_enter_rst();
      m_attempt = 0;
      m_run     = 0;
      m_retries = 0;
      m_clear_hist();
      return;
    end
    case (m_phase)
      P_RST: begin
        m_elapsed++;
        if (m_elapsed == RST_CYCLES) begin
          m_phase   = P_WAIT;
          m_attempt = 0;
        end
      end
      P_WAIT: begin
        m_attempt++;
        if (m_attempt == LOCK_TIMEOUT) m_timeout();
        else if (ls) begin
          m_phase = P_STABLE;
          m_run   = 0;
        end
      end
      P_STABLE: begin
        m_attempt++;
        if (ls) m_run++;
        if (ls && m_run == STABLE_CYCLES) m_phase = P_RUN;
        else if (m_attempt == LOCK_TIMEOUT) m_timeout();
        else if (!ls) begin
          m_phase = P_WAIT;
          m_run   = 0;
        end
      end
      P_RUN: begin
        if (!ls || relock_req) begin
          m_retries = 0;
          m_enter_rst();
        end
      end
      default: begin
        if (relock_req) begin
          m_retries = 0;
          m_enter_rst();
        end
      end
    endcase
    void'(m_hist.pop_front());
    m_hist.push_back(pll_locked);
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    v = '0;
    v[8:6] = 3'(m_phase);
    v[5]   = (m_phase == P_RST) || (m_phase == P_FAULT);
    v[4]   = (m_phase != P_RUN);
    v[3]   = (m_phase == P_RUN);
    v[2]   = (m_phase == P_FAULT);
    v[1:0] = 2'(m_retries);
    return v;
  endfunction

  function automatic logic [31:0] dut_vec();
    return {23'b0, state, pll_rst, sys_rst, ready, fault, retry_count};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    check("cycle", dut_vec(), model_vec());
    if (prev_state == P_STABLE && state == 3'(P_WAIT)) stable_drops++;
    prev_state = int'(state);
  endtask

  task automatic wait_state(input int s, input int bound, input string tag);
    int n;
    n = 0;
    while (state !== 3'(s) && n < bound) begin
      step();
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_ready(input int bound, input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    check(tag, 32'(ready), 32'd1);
  endtask

  initial begin
    int n, w, hold;
    bit prevp, sys_low;
    int highs[$], lows[$], rises[$];

    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    m_enter_rst(); m_attempt = 0; m_run = 0; m_retries = 0; m_clear_hist();

    // Reset values
    repeat (3) step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_sys_rst", 32'(sys_rst), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_retry", 32'(retry_count), 32'd0);

    // 1: PLL reset pulse width, then release latency from lock at edge 10
    rst = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin step(); n++; end
    check("t1_pll_rst_width", 32'(n), 32'(RST_CYCLES));
    repeat (10 - RST_CYCLES) step();
    pll_locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin step(); n++; end
    check("t1_release_latency", 32'(n), 32'd11);
    check("t1_sys_rst", 32'(sys_rst), 32'd0);
    check("t1_retry", 32'(retry_count), 32'd0);

    // 4: lock loss while running
    repeat (3) step();
    pll_locked = 1'b0;
    n = 0;
    while (sys_rst !== 1'b1 && n < 20) begin step(); n++; end
    check("t4_loss_latency", 32'(n), 32'd3);
    check("t4_ready", 32'(ready), 32'd0);
    check("t4_state", 32'(state), 32'(P_RST));
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin step(); n++; end
    check("t4_pll_rst_width", 32'(n), 32'(RST_CYCLES));
    pll_locked = 1'b1;
    wait_ready(60, "t4_resequence_ready");
    check("t4_retry", 32'(retry_count), 32'd0);

    // 3: one-cycle lock glitch in STABLE
    pll_locked = 1'b0;
    wait_state(P_WAIT, 40, "t3_reach_wait");
    stable_drops = 0;
    pll_locked = 1'b1;
    repeat (5) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_ready(40, "t3_released");
    check("t3_stable_to_wait", 32'(stable_drops), 32'd1);
    check("t3_retry", 32'(retry_count), 32'd0);

    // 2: no lock at all -> three attempts, then fault
    rst = 1'b1; pll_locked = 1'b0;
    step(); step();
    rst = 1'b0;
    w = 1; prevp = 1'b1; sys_low = 1'b0; n = 0;
    while (fault !== 1'b1 && n < 300) begin
      step();
      n++;
      if (sys_rst !== 1'b1) sys_low = 1'b1;
      if (pll_rst === prevp) w++;
      else begin
        if (prevp) highs.push_back(w);
        else begin
          lows.push_back(w);
          rises.push_back(int'(retry_count));
        end
        w = 1;
        prevp = pll_rst;
      end
    end
    check("t2_fault", 32'(fault), 32'd1);
    check("t2_pll_rst_held", 32'(pll_rst), 32'd1);
    check("t2_sys_rst_never_low", 32'(sys_low), 32'd0);
    check("t2_pulse_count", 32'(highs.size()), 32'd3);
    check("t2_wait_count", 32'(lows.size()), 32'd3);
    for (int i = 0; i < highs.size(); i++) check("t2_pulse_width", 32'(highs[i]), 32'(RST_CYCLES));
    for (int i = 0; i < lows.size(); i++) check("t2_wait_width", 32'(lows[i]), 32'(LOCK_TIMEOUT));
    if (rises.size() == 3) begin
      check("t2_retry_after_1st", 32'(rises[0]), 32'd1);
      check("t2_retry_after_2nd", 32'(rises[1]), 32'd2);
      check("t2_retry_at_fault", 32'(rises[2]), 32'd2);
    end
    repeat (5) step();
    check("t2_fault_sticky", 32'(fault), 32'd1);

    // 5: relock in FAULT restarts; relock in WAIT_LOCK is ignored
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    check("t5_fault_cleared", 32'(fault), 32'd0);
    check("t5_state_pll_rst", 32'(state), 32'(P_RST));
    check("t5_retry_cleared", 32'(retry_count), 32'd0);
    wait_state(P_WAIT, 20, "t5_reach_wait");
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    check("t5_relock_in_wait_ignored", 32'(state), 32'(P_WAIT));
    check("t5_pll_rst_low", 32'(pll_rst), 32'd0);

    // 6: reset mid-STABLE and mid-RUN
    pll_locked = 1'b1;
    wait_state(P_STABLE, 20, "t6_reach_stable");
    step(); step();
    rst = 1'b1;
    step();
    check("t6_stable_rst_state", 32'(state), 32'(P_RST));
    check("t6_stable_rst_pll_rst", 32'(pll_rst), 32'd1);
    check("t6_stable_rst_sys_rst", 32'(sys_rst), 32'd1);
    rst = 1'b0;
    wait_ready(60, "t6_ready_after_stable_rst");
    repeat (4) step();
    rst = 1'b1;
    step();
    check("t6_run_rst_state", 32'(state), 32'(P_RST));
    check("t6_run_rst_ready", 32'(ready), 32'd0);
    check("t6_run_rst_sys_rst", 32'(sys_rst), 32'd1);
    rst = 1'b0;
    wait_ready(60, "t6_ready_after_run_rst");

    // Randomized lock behaviour, relock pulses and occasional resets
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pll_locked = ~pll_locked;
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 30));
      end
      hold--;
      relock_req = ($urandom_range(0, 39) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; relock_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
